regfile_wb_arbiter: RTL and testbench

- Owns the single write port of the 8x8 register file and shares it between two writeback requesters: port 0 is the ALU and port 1 is the load/memory unit.
- Arbitration between the two is round-robin, and the write to the register file is registered.
- Keeps a per-register scoreboard of outstanding writes so decode can detect RAW/WAW hazards on both read ports.
- Sits between the execute/memory stages and register_file; decode drives the reservation and hazard-check inputs.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_scoreboard.sv | 54 +++++
 rtl/regfile_wb_arbiter.sv | 96 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared widths and constants for the register file writeback path.
// Requester indices and register-zero address live here too.
package regfile_pkg;
  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 8;
  localparam int CNT_W    = 2;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  localparam logic WB_ALU = 1'b0;
  localparam logic WB_MEM = 1'b1;
endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write counters for decode hazard detection.
// Saturating at CNT_MAX, clamped at zero, simultaneous inc/dec holds.
module regfile_scoreboard
  import regfile_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_inc_valid,
  input  logic [ADDR_W-1:0] i_inc_addr,
  input  logic              i_dec_valid,
  input  logic [ADDR_W-1:0] i_dec_addr,
  input  logic [ADDR_W-1:0] i_chk_addr_a,
  input  logic [ADDR_W-1:0] i_chk_addr_b,
  output logic              o_busy_a,
  output logic              o_busy_b,
  input  logic [ADDR_W-1:0] i_sat_addr,
  output logic              o_sat,
  output logic              o_underflow
);

  logic [CNT_W-1:0]    r_cnt [NUM_REGS];
  logic [NUM_REGS-1:0] w_inc;
  logic [NUM_REGS-1:0] w_dec;

  always_comb begin
    w_inc = '0;
    w_dec = '0;
    w_inc[i_inc_addr] = i_inc_valid;
    w_dec[i_dec_addr] = i_dec_valid;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_REGS; i++)
        r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_inc[i] && !w_dec[i] &&
            r_cnt[i] != CNT_MAX)
          r_cnt[i] <= r_cnt[i] + 1'b1;
        else if (w_dec[i] && !w_inc[i] &&
                 r_cnt[i] != '0)
          r_cnt[i] <= r_cnt[i] - 1'b1;
      end
    end
  end

  assign o_busy_a    = (r_cnt[i_chk_addr_a] != '0);
  assign o_busy_b    = (r_cnt[i_chk_addr_b] != '0);
  assign o_sat       = (r_cnt[i_sat_addr] == CNT_MAX);
  assign o_underflow = i_dec_valid &&
                       (r_cnt[i_dec_addr] == '0);

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the register file write port (ALU vs load).
// Registers the winning write and tracks pending writes per register.
module regfile_wb_arbiter
  import regfile_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rsv_valid,
  input  logic [ADDR_W-1:0] i_rsv_addr,
  output logic              o_rsv_ready,
  input  logic              i_alu_valid,
  input  logic [ADDR_W-1:0] i_alu_addr,
  input  logic [DATA_W-1:0] i_alu_data,
  output logic              o_alu_ready,
  input  logic              i_mem_valid,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [DATA_W-1:0] i_mem_data,
  output logic              o_mem_ready,
  input  logic [ADDR_W-1:0] i_chk_addr_a,
  input  logic [ADDR_W-1:0] i_chk_addr_b,
  output logic              o_busy_a,
  output logic              o_busy_b,
  output logic              o_rf_we,
  output logic [ADDR_W-1:0] o_rf_waddr,
  output logic [DATA_W-1:0] o_rf_wdata,
  output logic              o_wb_underflow
);

  logic              r_last;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;

  logic              w_alu_gnt;
  logic              w_mem_gnt;
  logic              w_gnt;
  logic [ADDR_W-1:0] w_gnt_addr;
  logic [DATA_W-1:0] w_gnt_data;
  logic              w_sat;
  logic              w_inc;

  assign w_alu_gnt = i_alu_valid &&
                     (!i_mem_valid || r_last == WB_MEM);
  assign w_mem_gnt = i_mem_valid &&
                     (!i_alu_valid || r_last == WB_ALU);
  assign w_gnt     = w_alu_gnt || w_mem_gnt;

  assign w_gnt_addr = w_alu_gnt ? i_alu_addr : i_mem_addr;
  assign w_gnt_data = w_alu_gnt ? i_alu_data : i_mem_data;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last  <= WB_MEM;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      // R0 writes still consume the slot, but never reach the file
      r_we <= w_gnt && (w_gnt_addr != REG_ZERO);
      if (w_gnt) begin
        r_last  <= w_mem_gnt;
        r_waddr <= w_gnt_addr;
        r_wdata <= w_gnt_data;
      end
    end
  end

  // A full counter frees up if its own write retires this cycle
  assign o_rsv_ready = (i_rsv_addr == REG_ZERO) || !w_sat ||
                       (r_we && r_waddr == i_rsv_addr);
  assign w_inc = i_rsv_valid && o_rsv_ready &&
                 (i_rsv_addr != REG_ZERO);

  regfile_scoreboard u_sb (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_inc_valid  (w_inc),
    .i_inc_addr   (i_rsv_addr),
    .i_dec_valid  (r_we),
    .i_dec_addr   (r_waddr),
    .i_chk_addr_a (i_chk_addr_a),
    .i_chk_addr_b (i_chk_addr_b),
    .o_busy_a     (o_busy_a),
    .o_busy_b     (o_busy_b),
    .i_sat_addr   (i_rsv_addr),
    .o_sat        (w_sat),
    .o_underflow  (o_wb_underflow)
  );

  assign o_alu_ready = w_alu_gnt;
  assign o_mem_ready = w_mem_gnt;
  assign o_rf_we     = r_we;
  assign o_rf_waddr  = r_waddr;
  assign o_rf_wdata  = r_wdata;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed cases then random traffic.
// A cycle-level reference model supplies every expected value.
module tb_regfile_wb_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       rsv_valid;
  logic [2:0] rsv_addr;
  logic       rsv_ready;
  logic       alu_valid;
  logic [2:0] alu_addr;
  logic [7:0] alu_data;
  logic       alu_ready;
  logic       mem_valid;
  logic [2:0] mem_addr;
  logic [7:0] mem_data;
  logic       mem_ready;
  logic [2:0] chk_a;
  logic [2:0] chk_b;
  logic       busy_a;
  logic       busy_b;
  logic       rf_we;
  logic [2:0] rf_waddr;
  logic [7:0] rf_wdata;
  logic       wb_underflow;

  int n_chk = 0;
  int n_err = 0;

  int m_cnt [8];
  int m_last;
  bit m_we;
  int m_waddr;
  int m_wdata;
  bit m_ga;
  bit m_gm;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_rsv_valid    (rsv_valid),
    .i_rsv_addr     (rsv_addr),
    .o_rsv_ready    (rsv_ready),
    .i_alu_valid    (alu_valid),
    .i_alu_addr     (alu_addr),
    .i_alu_data     (alu_data),
    .o_alu_ready    (alu_ready),
    .i_mem_valid    (mem_valid),
    .i_mem_addr     (mem_addr),
    .i_mem_data     (mem_data),
    .o_mem_ready    (mem_ready),
    .i_chk_addr_a   (chk_a),
    .i_chk_addr_b   (chk_b),
    .o_busy_a       (busy_a),
    .o_busy_b       (busy_b),
    .o_rf_we        (rf_we),
    .o_rf_waddr     (rf_waddr),
    .o_rf_wdata     (rf_wdata),
    .o_wb_underflow (wb_underflow)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h @%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_cnt[i] = 0;
    m_last  = 1;
    m_we    = 0;
    m_waddr = 0;
    m_wdata = 0;
    m_ga    = 0;
    m_gm    = 0;
  endtask

  task automatic idle();
    rsv_valid = 0; rsv_addr = 0;
    alu_valid = 0; alu_addr = 0; alu_data = 0;
    mem_valid = 0; mem_addr = 0; mem_data = 0;
  endtask

  // Called at negedge with inputs set; checks, then advances one cycle
  task automatic step();
    bit ga, gm, rr, inc, nwe;
    #1;
    ga = alu_valid && (!mem_valid || m_last == 1);
    gm = mem_valid && (!alu_valid || m_last == 0);
    rr = rsv_addr == 0 || m_cnt[rsv_addr] < 3 ||
         (m_we && m_waddr == int'(rsv_addr));
    chk("alu_ready", alu_ready, ga);
    chk("mem_ready", mem_ready, gm);
    chk("rsv_ready", rsv_ready, rr);
    chk("busy_a", busy_a, m_cnt[chk_a] != 0);
    chk("busy_b", busy_b, m_cnt[chk_b] != 0);
    chk("rf_we", rf_we, m_we);
    chk("underflow", wb_underflow,
        m_we && m_cnt[m_waddr] == 0);
    if (m_we) begin
      chk("rf_waddr", rf_waddr, m_waddr);
      chk("rf_wdata", rf_wdata, m_wdata);
    end
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      inc = rsv_valid && rr && rsv_addr != 0;
      if (inc && m_we && m_waddr == int'(rsv_addr)) begin
      end else begin
        if (inc && m_cnt[rsv_addr] < 3)
          m_cnt[rsv_addr]++;
        if (m_we && m_cnt[m_waddr] > 0)
          m_cnt[m_waddr]--;
      end
      nwe = (ga && alu_addr != 0) || (gm && mem_addr != 0);
      if (ga) begin
        m_waddr = alu_addr; m_wdata = alu_data; m_last = 0;
      end else if (gm) begin
        m_waddr = mem_addr; m_wdata = mem_data; m_last = 1;
      end
      m_we = nwe;
      m_ga = ga;
      m_gm = gm;
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1; idle(); chk_a = 0; chk_b = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    chk("rst_we", rf_we, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_uf", wb_underflow, 0);
    step();

    alu_valid = 1; alu_addr = 3; alu_data = 8'hA5;
    #1 chk("t1_ready", alu_ready, 1);
    step();
    idle();
    chk("t1_we", rf_we, 1);
    chk("t1_waddr", rf_waddr, 3);
    chk("t1_wdata", rf_wdata, 8'hA5);
    step();
    chk("t1_we_off", rf_we, 0);

    alu_valid = 1; alu_addr = 1; alu_data = 8'h11;
    mem_valid = 1; mem_addr = 4; mem_data = 8'h44;
    repeat (4) begin
      #1 chk("tie_onehot", alu_ready && mem_ready, 0);
      step();
    end
    idle();
    step();

    rsv_valid = 1; rsv_addr = 5; chk_a = 5; chk_b = 5;
    step();
    idle();
    #1 chk("r5_busy", busy_a, 1);
    step();
    alu_valid = 1; alu_addr = 5; alu_data = 8'h55;
    step();
    idle();
    #1 chk("r5_busy_n1", busy_a, 1);
    step();
    chk("r5_busy_n2", busy_a, 0);
    step();

    rsv_valid = 1; rsv_addr = 2; chk_a = 2;
    repeat (3) step();
    #1 chk("sat_block", rsv_ready, 0);
    step();
    rsv_valid = 0; alu_valid = 1; alu_addr = 2; alu_data = 8'h22;
    step();
    idle();
    rsv_valid = 1; rsv_addr = 2;
    #1 chk("sat_retry", rsv_ready, 1);
    step();
    idle();
    step();

    mem_valid = 1; mem_addr = 0; mem_data = 8'hFF; chk_b = 0;
    rsv_valid = 1; rsv_addr = 0;
    #1 chk("r0_ready", mem_ready, 1);
    #0 chk("r0_rsv", rsv_ready, 1);
    step();
    idle();
    chk("r0_we", rf_we, 0);
    chk("r0_busy", busy_b, 0);
    mem_valid = 1; mem_addr = 6; mem_data = 8'h66; chk_a = 6;
    step();
    idle();
    chk("uf_pulse", wb_underflow, 1);
    step();
    chk("uf_clear", wb_underflow, 0);

    alu_valid = 1; alu_addr = 4; alu_data = 8'h9C;
    step();
    idle(); rst = 1;
    step();
    rst = 0;
    chk("rstw_we", rf_we, 0);
    chk("rstw_busy", busy_a, 0);
    step();
    alu_valid = 1; alu_addr = 1; alu_data = 8'h01;
    mem_valid = 1; mem_addr = 7; mem_data = 8'h07;
    #1 chk("rst_tie_alu", alu_ready, 1);
    step();
    idle();
    step();

    for (int c = 0; c < 600; c++) begin
      if (!(alu_valid && !m_ga)) begin
        alu_valid = 1'($urandom_range(0, 1));
        alu_addr  = 3'($urandom_range(0, 3));
        alu_data  = 8'($urandom);
      end
      if (!(mem_valid && !m_gm)) begin
        mem_valid = 1'($urandom_range(0, 1));
        mem_addr  = 3'($urandom_range(0, 3));
        mem_data  = 8'($urandom);
      end
      rsv_valid = ($urandom_range(0, 9) < 7);
      rsv_addr  = 3'($urandom_range(0, 3));
      chk_a     = 3'($urandom_range(0, 7));
      chk_b     = 3'($urandom_range(0, 7));
      rst       = ($urandom_range(0, 99) == 0);
      step();
      rst = 0;
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
